alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2).
REQ-002 Parameter: NREG, 8, register-file entries, 8 bits each.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: instr_valid  in  1  instruction offered.
REQ-006 Port: instr_data  in  12  [11:9] opcode, [8:6] dst, [5:3] srcA, [2:0] srcB.
REQ-007 Port: instr_ready  out  1  FIFO can accept; high when FIFO not full.
REQ-008 Port: wr_en / wr_addr / wr_data  in  1/3/8  host register-file load.
REQ-009 Port: alu_a, alu_b  out  8  registered operands to the ALU.
REQ-010 Port: alu_op  out  3  registered opcode to the ALU.
REQ-011 Port: alu_out  in  8; alu_cout  in  1; alu_z  in  1  combinational ALU results.
REQ-012 Port: res_valid  out  1  one-cycle pulse per completed instruction.
REQ-013 Port: res_data  out  8  result of last completed instruction; held.
REQ-014 Port: c_flag, z_flag  out  1  carry/zero of last completed instruction; held.
REQ-015 Port: busy  out  1  high when state is not IDLE or FIFO not empty.

Function
REQ-016 Transfer SHALL occur on a rising edge with instr_valid and instr_ready both high; instr_valid while instr_ready low SHALL be ignored.
REQ-017 FIFO SHALL be first-in-first-out; pointers wrap modulo FIFO_DEPTH; separate count distinguishes full from empty.
REQ-018 FSM states: IDLE, ISSUE, CAPTURE, WB.
REQ-019 IDLE -> ISSUE when FIFO non-empty, popping the head entry; otherwise remain IDLE.
REQ-020 ISSUE: register alu_a=reg[srcA], alu_b=reg[srcB], alu_op=opcode, latch dst; -> CAPTURE.
REQ-021 CAPTURE: register alu_out, alu_cout, alu_z internally; -> WB.
REQ-022 WB: write captured result to reg[dst]; update res_data, c_flag, z_flag; res_valid=1 for this cycle only; -> IDLE.
REQ-023 Latency: instruction pushed on edge T into empty FIFO with FSM IDLE produces res_valid in cycle T+4 (pop at T+1, issue T+2, capture T+3, WB T+4 edge, pulse visible after T+3 edge... counted as res_valid high during cycle following 3rd post-push edge); throughput one instruction per 4 cycles.
REQ-024 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-025 Instructions execute strictly in order; each reads the register file after the previous WB, so back-to-back dependent instructions see updated values (no forwarding needed).
REQ-026 Host write on an edge with FSM in WB SHALL be dropped if wr_addr equals dst; otherwise both writes occur.
REQ-027 Host write to an address read in the same ISSUE edge: ISSUE reads the old value.
REQ-028 Register file widths are 8 bits; no sign extension; addresses 3 bits cover all NREG entries.
REQ-029 alu_a, alu_b, alu_op, res_data, c_flag, z_flag SHALL hold value outside the state that updates them.

Reset
REQ-030 On rst high, asynchronously: state IDLE, FIFO empty (instr_ready=1), all registers 0, alu_a=alu_b=0, alu_op=000, res_valid=0, res_data=0, c_flag=0, z_flag=0, busy=0.
REQ-031 Reset mid-instruction SHALL discard the in-flight instruction and all queued entries; no res_valid is produced for them.
REQ-032 First edge after rst deasserts SHALL behave as normal operation.

Verification
REQ-033 Load reg1=0x0F, reg2=0xF1; push {op=000,dst=3,A=1,B=2} -> res_valid once, res_data=0x00, c_flag=1, z_flag=1, reg3=0x00.
REQ-034 Push 4 instructions with instr_valid held high while FSM blocked on first -> instr_ready low after 4th accept held in FIFO (5th offer ignored), results emerge in push order.
REQ-035 Chain {op=000,dst=1,A=1,B=1} twice with reg1=0x03 -> res_data 0x06 then 0x0C.
REQ-036 Host write reg[dst]=0xAA on WB edge of instruction writing 0x55 to same dst -> reg[dst]=0x55.
REQ-037 Assert rst during CAPTURE with 2 queued entries -> no res_valid, instr_ready=1, busy=0, all outputs 0.
REQ-038 Simultaneous push and pop with FIFO holding 2 entries -> count remains 2, order preserved.

Source files
------------

// File: rtl/alu_seq.sv
// Instruction sequencer: queues 12-bit instructions, reads an 8-bit register file,
// drives an external combinational ALU and writes the result back, one instruction per four cycles.
module alu_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int NREG       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [11:0] instr_data,
    output logic        instr_ready,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic        alu_cout,
    input  logic        alu_z,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        c_flag,
    output logic        z_flag,
    output logic        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WB} state_t;
    state_t state, next_state;

    logic [11:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    logic [11:0]      cur;
    logic [2:0]       dst;
    logic [7:0]       regs [NREG];

    assign instr_ready = (count != FULL);
    assign push        = instr_valid && instr_ready;
    assign busy        = (state != IDLE) || (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = WB;
            WB: begin
                res_valid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Separate occupancy count disambiguates full from empty when the pointers meet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= instr_data;
    end

    // Result registers load on the capture edge so the new value is visible alongside res_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= '0;
            dst      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            res_data <= '0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
        end else begin
            if (pop) cur <= fifo_mem[rptr];
            if (state == ISSUE) begin
                alu_a  <= regs[cur[5:3]];
                alu_b  <= regs[cur[2:0]];
                alu_op <= cur[11:9];
                dst    <= cur[8:6];
            end
            if (state == CAPTURE) begin
                res_data <= alu_out;
                c_flag   <= alu_cout;
                z_flag   <= alu_z;
            end
        end
    end

    // Write-back wins over a host write to the same address on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wr_en && !(state == WB && wr_addr == dst)) regs[wr_addr] <= wr_data;
            if (state == WB) regs[dst] <= res_data;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: bench-side ALU, transaction-level timing model with per-cycle compare,
// and directed scenarios with hand-computed results.
module tb_alu_seq;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [11:0] instr_data;
    logic        instr_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_cout, alu_z;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        c_flag, z_flag, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.FIFO_DEPTH(DEPTH), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_z(alu_z),
        .res_valid(res_valid), .res_data(res_data),
        .c_flag(c_flag), .z_flag(z_flag), .busy(busy)
    );

    // ALU semantics: 0 add, 1 sub (borrow), 2 and, 3 or, 4 xor, 5 pass a, 6 not a, 7 pass b.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    alu_f = {1'b0, a} + {1'b0, b};
            3'd1:    alu_f = {1'b0, a} - {1'b0, b};
            3'd2:    alu_f = {1'b0, a & b};
            3'd3:    alu_f = {1'b0, a | b};
            3'd4:    alu_f = {1'b0, a ^ b};
            3'd5:    alu_f = {1'b0, a};
            3'd6:    alu_f = {1'b0, ~a};
            default: alu_f = {1'b0, b};
        endcase
    endfunction

    assign {alu_cout, alu_out} = alu_f(alu_op, alu_a, alu_b);
    assign alu_z = (alu_out == 8'h00);

    function automatic logic [11:0] ins(input int op, input int d, input int a, input int b);
        ins = {op[2:0], d[2:0], a[2:0], b[2:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Model: each instruction pops at edge P, issues at P+1, captures at P+2, writes back at P+3.
    logic [7:0]  mregs [8];
    logic [11:0] pend [$];
    bit          infl;
    int          pop_e, e;
    logic [11:0] mcur;
    logic [7:0]  ma, mb, cres, lres;
    logic [2:0]  mop;
    logic        cc, cz, lc, lz;

    always @(negedge clk) begin
        int nx;
        bit do_pop, acc, wb;
        if (rst) begin
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_flags", {c_flag, z_flag}, 0);
            chk("rst_alu_regs", {alu_a, alu_b, alu_op}, 0);
            chk("rst_instr_ready", instr_ready, 1);
            chk("rst_busy", busy, 0);
            for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
            pend.delete();
            infl = 0; pop_e = 0; e = 0; mcur = '0;
            ma = '0; mb = '0; mop = '0; cres = '0; cc = 0; cz = 0;
            lres = '0; lc = 0; lz = 0;
        end else begin
            chk("res_valid", res_valid, infl && (e == pop_e + 2));
            chk("res_data", res_data, lres);
            chk("c_flag", c_flag, lc);
            chk("z_flag", z_flag, lz);
            chk("alu_operands", {alu_a, alu_b, alu_op}, {ma, mb, mop});
            chk("instr_ready", instr_ready, pend.size() < DEPTH);
            chk("busy", busy, infl || (pend.size() > 0));
            nx = e + 1;
            do_pop = !infl && (pend.size() > 0);
            acc = instr_valid && (pend.size() < DEPTH);
            wb = infl && (nx == pop_e + 3);
            if (infl && nx == pop_e + 1) begin
                ma = mregs[mcur[5:3]];
                mb = mregs[mcur[2:0]];
                mop = mcur[11:9];
                {cc, cres} = alu_f(mop, ma, mb);
                cz = (cres == 8'h00);
            end
            if (infl && nx == pop_e + 2) begin
                lres = cres; lc = cc; lz = cz;
            end
            if (wr_en && !(wb && wr_addr == mcur[8:6])) mregs[wr_addr] = wr_data;
            if (wb) begin
                mregs[mcur[8:6]] = cres;
                infl = 0;
            end
            if (do_pop) begin
                mcur = pend.pop_front();
                infl = 1;
                pop_e = nx;
            end
            if (acc) pend.push_back(instr_data);
            e = nx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a[2:0]; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push(input logic [11:0] d);
        logic rdy;
        int n;
        instr_valid = 1'b1;
        instr_data = d;
        n = 0;
        do begin
            rdy = instr_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        instr_valid = 1'b0;
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL push_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        if (!res_valid) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_res_valid required=res_valid", name);
        end
    endtask

    task automatic wait_res(input string name, input logic [7:0] d, input logic c, input logic z);
        wait_valid(name);
        chk(name, {res_data, c_flag, z_flag}, {d, c, z});
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_data = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) tick();
        chk("reset_ready", instr_ready, 1);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Add with carry-out and zero result, then read back the written register.
        hwrite(1, 8'h0F);
        hwrite(2, 8'hF1);
        push(ins(0, 3, 1, 2));
        wait_res("add_wrap", 8'h00, 1'b1, 1'b1);
        push(ins(0, 4, 3, 1));
        wait_res("reg3_readback", 8'h0F, 1'b0, 1'b0);

        // Dependent chain: second instruction sees the first result.
        hwrite(1, 8'h03);
        push(ins(0, 1, 1, 1));
        push(ins(0, 1, 1, 1));
        wait_res("chain_first", 8'h06, 1'b0, 1'b0);
        wait_res("chain_second", 8'h0C, 1'b0, 1'b0);

        // Valid held high across a full FIFO; order checked per cycle, final value pins it.
        wait_idle();
        begin
            logic [11:0] list [6];
            list[0] = ins(4, 5, 1, 2);
            list[1] = ins(1, 6, 2, 1);
            list[2] = ins(2, 7, 2, 4);
            list[3] = ins(3, 5, 5, 4);
            list[4] = ins(0, 6, 6, 7);
            list[5] = ins(5, 7, 6, 0);
            for (int k = 0; k < 6; k++) begin
                push(list[k]);
                if (k == 4) chk("full_not_ready", instr_ready, 0);
            end
        end
        wait_idle();
        push(ins(5, 3, 7, 0));
        wait_res("order_last", 8'hE6, 1'b0, 1'b0);
        push(ins(5, 3, 5, 0));
        wait_res("order_or", 8'hFF, 1'b0, 1'b0);

        // Host write to dst on the write-back edge is dropped.
        hwrite(6, 8'h55);
        push(ins(3, 5, 6, 0));
        wait_valid("wb_instr");
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        push(ins(5, 7, 5, 0));
        wait_res("wb_host_drop", 8'h55, 1'b0, 1'b0);

        // Host write to a source register on the issue edge: issue reads the old value.
        wait_idle();
        instr_valid = 1'b1; instr_data = ins(5, 7, 6, 0);
        tick();
        instr_valid = 1'b0;
        tick();
        hwrite(6, 8'h11);
        wait_res("issue_old", 8'h55, 1'b0, 1'b0);
        push(ins(5, 7, 6, 0));
        wait_res("issue_new", 8'h11, 1'b0, 1'b0);

        // Push coinciding with a pop while two entries are queued.
        wait_idle();
        hwrite(1, 8'h01);
        push(ins(0, 1, 1, 1));
        push(ins(0, 1, 1, 1));
        push(ins(0, 1, 1, 1));
        tick();
        tick();
        push(ins(0, 1, 1, 1));
        push(ins(0, 1, 1, 1));
        push(ins(0, 1, 1, 1));
        chk("pushpop_full", instr_ready, 0);
        wait_idle();
        push(ins(5, 2, 1, 0));
        wait_res("pushpop_final", 8'h40, 1'b0, 1'b0);

        // Reset during capture with two entries queued.
        wait_idle();
        push(ins(0, 2, 1, 1));
        push(ins(0, 2, 1, 1));
        push(ins(0, 2, 1, 1));
        chk("pre_rst_alu_a", alu_a, 8'h40);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {res_valid, res_data, c_flag, z_flag, alu_a}, 0);
        chk("mid_rst_ready_busy", {instr_ready, busy}, 2'b10);
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("post_rst_quiet", {res_valid, busy}, 0);
        push(ins(0, 3, 1, 2));
        wait_res("post_rst_zero", 8'h00, 1'b0, 1'b1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
